// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures words from a flag-style UART receiver into a show-ahead FIFO.
// Define UART_RX_FIFO_PARITY_EN to store the receiver parity-error bit with each word.
module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_flag,
    input  logic              rx_perr,
    output logic              clr_rx_flag,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_perr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              rx_irq
);

`ifdef UART_RX_FIFO_PARITY_EN
    localparam int unsigned EntryW = DATA_W + 1;
`else
    localparam int unsigned EntryW = DATA_W;
`endif
    localparam logic [ADDR_W:0] FullCount = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StClear, StWaitLow} state_e;

    state_e            state_q;
    logic [EntryW-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] head;
    logic              capture;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FullCount);
    assign count  = count_q;
    assign rx_irq = !empty;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign capture = (state_q == StIdle) && rx_flag;
    assign do_pop  = rd_en && !empty;
    assign do_push = capture && (!full || do_pop);
    assign drop    = capture && full && !do_pop;
    assign head    = mem_q[rd_ptr_q];

`ifdef UART_RX_FIFO_PARITY_EN
    assign wr_entry = {rx_perr, rx_data};
    assign rd_perr  = empty ? 1'b0 : head[DATA_W];
`else
    logic unused_rx_perr;
    assign unused_rx_perr = rx_perr;
    assign wr_entry       = rx_data;
    assign rd_perr        = 1'b0;
`endif
    assign rd_data = empty ? '0 : head[DATA_W-1:0];

    // One capture per rx_flag assertion: wait for the receiver to drop the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            clr_rx_flag <= 1'b0;
        end else begin
            clr_rx_flag <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (rx_flag) begin
                        state_q     <= StClear;
                        clr_rx_flag <= 1'b1;
                    end
                end
                StClear:   state_q <= StWaitLow;
                StWaitLow: if (!rx_flag) state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the received word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the FIFO entry count; it is a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_W, default log2(DEPTH)=3, meaning the FIFO pointer width.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port rx_data, input, DATA_W bits: parallel word from the UART receiver.
REQ-007 The block SHALL have port rx_flag, input, 1 bit: level, high while the receiver holds an unread word.
REQ-008 The block SHALL have port rx_perr, input, 1 bit: receiver parity-error indication, valid while rx_flag is high.
REQ-009 The block SHALL have port clr_rx_flag, output, 1 bit: registered one-cycle pulse that clears the receiver's rx_flag.
REQ-010 The block SHALL have port rd_en, input, 1 bit: CPU pop request, one entry per cycle it is high.
REQ-011 The block SHALL have port rd_data, output, DATA_W bits: head-of-FIFO word, show-ahead.
REQ-012 The block SHALL have port rd_perr, output, 1 bit: parity tag of the head entry.
REQ-013 The block SHALL have port empty, output, 1 bit: FIFO holds no entries.
REQ-014 The block SHALL have port full, output, 1 bit: FIFO holds DEPTH entries.
REQ-015 The block SHALL have port count, output, ADDR_W+1 bits: current occupancy, 0..DEPTH.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.
REQ-017 The block SHALL have port ovf_clr, input, 1 bit: synchronous clear of overflow.
REQ-018 The block SHALL have port rx_irq, output, 1 bit: equals !empty, for the CPU interrupt line.

Function
REQ-019 The capture FSM SHALL have states IDLE, CLEAR and WAIT_LOW.
REQ-020 In IDLE with rx_flag=1, the block SHALL push {rx_perr, rx_data} in the same cycle and go to CLEAR; if full and no pop occurs that cycle, it SHALL drop the word and set overflow instead.
REQ-021 In CLEAR, clr_rx_flag SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT_LOW.
REQ-022 In WAIT_LOW the FSM SHALL stay until rx_flag=0, then return to IDLE; a word is never captured twice.
REQ-023 A push SHALL be visible on rd_data, empty, count and rx_irq one cycle after the capture edge.
REQ-024 rd_en with empty=0 SHALL advance the read pointer; rd_data then shows the next entry on the following cycle.
REQ-025 rd_en with empty=1 SHALL be ignored: no pointer or count change and no error flag.
REQ-026 A simultaneous push and pop SHALL both take effect with count unchanged, including when full.
REQ-027 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-028 When ovf_clr and a new overflow event occur in the same cycle, set SHALL win.

Reset
REQ-029 On reset low, asynchronously: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, clr_rx_flag=0, rx_irq=0, rd_data=0, rd_perr=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; after release the FSM SHALL re-capture a still-high rx_flag as a new word.

Configuration
REQ-031 With macro UART_RX_FIFO_PARITY_EN defined, each entry SHALL be DATA_W+1 bits and rd_perr SHALL return the stored rx_perr.
REQ-032 Without UART_RX_FIFO_PARITY_EN, rx_perr SHALL be ignored, entries SHALL be DATA_W bits and rd_perr SHALL be tied 0.

Verification
REQ-033 The bench SHALL cover: rx_data=0xA5, rx_flag pulse -> one clr_rx_flag pulse, count=1, rd_data=0xA5, rx_irq=1.
REQ-034 The bench SHALL cover: 9 words 0x01..0x09 with no reads (DEPTH=8) -> full=1, overflow=1, reads return 0x01..0x08, then empty=1.
REQ-035 The bench SHALL cover: full FIFO, rd_en and capture in the same cycle -> count stays 8, last read after draining returns the new word.
REQ-036 The bench SHALL cover: rx_flag held high 20 cycles -> exactly one push and one clr_rx_flag pulse.
REQ-037 The bench SHALL cover: rx_perr=1 with 0x3C, macro defined -> rd_perr=1; macro undefined -> rd_perr=0.
REQ-038 The bench SHALL cover: reset pulsed with count=5 -> count=0, empty=1, overflow=0 immediately, without waiting for a clock.
